// File: rtl/tff_pulse_driver_pkg.sv
// Shared definitions for the tff pulse driver: FSM encoding, op codes and default sizes.
package tff_pulse_driver_pkg;

    localparam int RING_SEGS_DEF   = 59;
    localparam int READ_CYCLES_DEF = 60;
    // Cycles spent in RDONE so the 2-flop synchroniser tail has settled before capture.
    localparam int TAIL_CYCLES     = 2;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WGAP  = 3'd2,
        ST_READ  = 3'd3,
        ST_RRST  = 3'd4,
        ST_RDONE = 3'd5
    } state_t;

    function automatic int clamp_len(input int len, input int lim);
        return (len > lim) ? lim : len;
    endfunction

endpackage

// File: rtl/tff_pulse_driver_timer.sv
// Loadable down-counter shared by the WRITE, READ and RDONE durations.
module tff_pulse_driver_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);
    assign last = (count == W'(1));

endmodule

// File: rtl/tff_pulse_driver.sv
// Command front end for one tff cell: exact-length WE/RE pulses, reset strobe, read-back.
// Optional TFF_SHADOW_EN adds a shadow sum of writes and the rd_mismatch output.
//
//  state | meaning
//  IDLE  | in_ready=1, waiting for a command
//  WRITE | we=1 for min(in_data, RING_SEGS) cycles
//  WGAP  | one cycle with we=0 between writes
//  READ  | re=1 for READ_CYCLES cycles, out/carry sampled
//  RRST  | tff_rstb=0 for one cycle, synchroniser tail still counting
//  RDONE | wait for tail, result captured, rd_valid on the last cycle
module tff_pulse_driver
    import tff_pulse_driver_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int RING_SEGS   = RING_SEGS_DEF,
    parameter int READ_CYCLES = READ_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             we,
    output logic             re,
    output logic             tff_rstb,
    input  logic             tff_out,
    input  logic             tff_carry,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_carry
`ifdef TFF_SHADOW_EN
    ,
    output logic             rd_mismatch
`endif
);

    localparam int TW = $clog2(READ_CYCLES + 1);

    state_t           state, state_nxt;
    logic             accept;
    logic             tmr_load, tmr_done, tmr_last;
    logic [TW-1:0]    tmr_val;
    logic [WIDTH-1:0] wr_len;
    logic [WIDTH-1:0] count;
    logic             car_acc;
    logic [1:0]       sync_out, sync_car, cnt_en;
    logic             capture;

    assign accept  = in_valid && in_ready;
    assign wr_len  = WIDTH'(clamp_len(int'(in_data), RING_SEGS));
    assign capture = (state == ST_RDONE) && tmr_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    tmr_load = 1'b1;
                    if (in_op == OP_WRITE) begin
                        tmr_val   = TW'(wr_len - 1'b1);
                        state_nxt = (wr_len == '0) ? ST_WGAP : ST_WRITE;
                    end else begin
                        tmr_val   = TW'(READ_CYCLES - 1);
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_WRITE: if (tmr_done) state_nxt = ST_WGAP;
            ST_WGAP:  state_nxt = ST_IDLE;
            ST_READ:  if (tmr_done) state_nxt = ST_RRST;
            ST_RRST: begin
                tmr_load  = 1'b1;
                tmr_val   = TW'(TAIL_CYCLES);
                state_nxt = ST_RDONE;
            end
            ST_RDONE: if (tmr_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // rst feeds the strobes directly so they drop without waiting for a clock.
    always_comb begin
        in_ready = (state == ST_IDLE) && !rst;
        we       = (state == ST_WRITE);
        re       = (state == ST_READ);
        tff_rstb = !rst && (state != ST_RRST);
        rd_valid = (state == ST_RDONE) && tmr_done;
    end

    tff_pulse_driver_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done),
        .last     (tmr_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_out <= '0;
            sync_car <= '0;
            cnt_en   <= '0;
            count    <= '0;
            car_acc  <= 1'b0;
        end else begin
            sync_out <= {sync_out[0], tff_out};
            sync_car <= {sync_car[0], tff_carry};
            cnt_en   <= {cnt_en[0], (state == ST_READ)};
            if (accept && (in_op == OP_READ)) begin
                count   <= '0;
                car_acc <= 1'b0;
            end else if (cnt_en[1]) begin
                if (sync_out[1] && (count != '1)) begin
                    count <= count + 1'b1;
                end
                if (sync_car[1]) begin
                    car_acc <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_carry <= 1'b0;
        end else if (capture) begin
            rd_data  <= count;
            rd_carry <= car_acc;
        end
    end

`ifdef TFF_SHADOW_EN
    localparam int SW = 16;

    logic [SW-1:0]    shadow;
    logic             exp_carry;
    logic [WIDTH-1:0] exp_data;

    // Expected result is frozen in RRST, the same cycle the shadow clears with the ring.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            exp_carry <= 1'b0;
            exp_data  <= '0;
        end else if (state == ST_RRST) begin
            shadow    <= '0;
            exp_carry <= (int'(shadow) > RING_SEGS);
            exp_data  <= WIDTH'(int'(shadow) % (RING_SEGS + 1));
        end else if (accept && (in_op == OP_WRITE)) begin
            if ((int'(shadow) + int'(wr_len)) > (2**SW - 1)) begin
                shadow <= '1;
            end else begin
                shadow <= shadow + SW'(wr_len);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_mismatch <= 1'b0;
        end else if (capture) begin
            rd_mismatch <= ({car_acc, count} != {exp_carry, exp_data});
        end
    end
`endif

endmodule

// File: tb/tb_tff_pulse_driver.sv
// Scoreboard bench for tff_pulse_driver with a behavioural tff cell and randomized commands.
module tb_tff_pulse_driver;

    localparam int WIDTH = 6;
    localparam int RS    = 59;
    localparam int RC    = 60;
    localparam logic OP_W = 1'b0;
    localparam logic OP_R = 1'b1;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_op     = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             tff_out   = 1'b0;
    logic             tff_carry = 1'b0;
    logic             in_ready, we, re, tff_rstb, rd_valid, rd_carry;
    logic [WIDTH-1:0] rd_data;
`ifdef TFF_SHADOW_EN
    logic             rd_mismatch;
`endif

    tff_pulse_driver #(
        .WIDTH       (WIDTH),
        .RING_SEGS   (RS),
        .READ_CYCLES (RC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .we        (we),
        .re        (re),
        .tff_rstb  (tff_rstb),
        .tff_out   (tff_out),
        .tff_carry (tff_carry),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_carry  (rd_carry)
`ifdef TFF_SHADOW_EN
        ,
        .rd_mismatch (rd_mismatch)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int data;
        int carry;
        int acc;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      we_q[$];
    int      total        = 0;
    int      reads_issued = 0;
    int      reads_done   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Behavioural tff: ring of RS+1 states, wraps into a sticky carry, out high for count cycles of RE.
    int tff_cnt = 0;
    int re_k    = 0;
    always @(negedge clk) begin
        if (!tff_rstb) begin
            tff_cnt   = 0;
            tff_carry = 1'b0;
        end else if (we) begin
            if (tff_cnt == RS) begin
                tff_cnt   = 0;
                tff_carry = 1'b1;
            end else begin
                tff_cnt++;
            end
        end
        if (re) begin
            tff_out = (re_k < tff_cnt);
            re_k++;
        end else begin
            re_k    = 0;
            tff_out = 1'b0;
        end
    end

    int we_len = 0;
    int re_len = 0;
    int rb_len = 0;
    always @(negedge clk) begin
        if (rst) begin
            we_len = 0;
            re_len = 0;
            rb_len = 0;
        end else begin
            if (we) begin
                we_len++;
            end else if (we_len > 0) begin
                if (we_q.size() == 0) fail_now("we_pulse_unexpected");
                else check("we_width", we_len, we_q.pop_front());
                we_len = 0;
            end
            if (re) begin
                re_len++;
            end else if (re_len > 0) begin
                check("re_width", re_len, RC);
                re_len = 0;
            end
            if (!tff_rstb) begin
                rb_len++;
            end else if (rb_len > 0) begin
                check("rstb_width", rb_len, 1);
                rb_len = 0;
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    fail_now("rd_valid_unexpected");
                end else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    reads_done++;
                    check("rd_data", rd_data, e.data);
                    check("rd_carry", rd_carry, e.carry);
                    check("rd_latency", cyc - e.acc, RC + 3);
`ifdef TFF_SHADOW_EN
                    check("rd_mismatch", rd_mismatch, 0);
`endif
                end
            end
        end
    end

    // Called at a negedge; holds in_valid until accepted and records the expected response.
    task automatic issue(input logic op, input int d);
        int guard;
        int n;
        rd_exp_t e;
        guard    = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = WIDTH'(d);
        while (!in_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) begin
            fail_now("accept_timeout");
            return;
        end
        if (op == OP_R) begin
            e.data  = total % (RS + 1);
            e.carry = (total > RS) ? 1 : 0;
            e.acc   = cyc + 1;
            rd_q.push_back(e);
            reads_issued++;
            total = 0;
        end else begin
            n = (d > RS) ? RS : d;
            total += n;
            if (n > 0) we_q.push_back(n);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int g;
        g        = 0;
        in_valid = 1'b0;
        while (!(in_ready && rd_q.size() == 0 && we_q.size() == 0) && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (g >= 400) fail_now("idle_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_we", we, 0);
        check("rst_re", re, 0);
        check("rst_tff_rstb", tff_rstb, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_carry", rd_carry, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
        check("rstb_after_rst", tff_rstb, 1);

        // read of an empty ring
        issue(OP_R, 0);
        wait_idle();

        // accumulate to exactly the ring length
        issue(OP_W, 5);
        issue(OP_W, 7);
        issue(OP_W, 3);
        issue(OP_W, 0);
        issue(OP_W, 44);
        issue(OP_R, 0);
        wait_idle();

        // wrap into carry
        issue(OP_W, 40);
        issue(OP_W, 30);
        issue(OP_R, 0);
        wait_idle();

        // oversize write is clamped
        issue(OP_W, 63);
        issue(OP_R, 0);
        wait_idle();

        // reset 10 cycles into a read
        issue(OP_W, 12);
        issue(OP_R, 0);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_re", re, 0);
        check("midrst_we", we, 0);
        check("midrst_tff_rstb", tff_rstb, 0);
        check("midrst_in_ready", in_ready, 0);
        rd_q.delete();
        we_q.delete();
        reads_issued--;
        total = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", in_ready, 1);
        check("midrst_rd_data", rd_data, 0);
        repeat (80) @(negedge clk);
        issue(OP_R, 0);
        wait_idle();

        // in_valid held continuously with alternating ops
        issue(OP_W, 10);
        issue(OP_R, 0);
        issue(OP_W, 20);
        issue(OP_R, 0);
        issue(OP_W, 0);
        issue(OP_R, 0);
        issue(OP_W, 59);
        issue(OP_R, 0);
        wait_idle();

        // randomized mix
        repeat (30) begin
            issue(($urandom_range(0, 2) == 0) ? OP_R : OP_W, int'($urandom_range(0, 63)));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end
        issue(OP_R, 0);
        wait_idle();

        check("rd_queue_empty", rd_q.size(), 0);
        check("we_queue_empty", we_q.size(), 0);
        check("reads_completed", reads_done, reads_issued);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
